// File: rtl/clk_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : clk_freq_meter
// Purpose  : Counts rising edges of an asynchronous clock (meas_clk) over a
//            fixed gate window of sys_clk cycles, reports the count, and flags
//            whether it lies within EXP_CNT +/- TOL or saturated.
// Ports    : sys_clk   - sole clock, all logic on rising edge
//            sys_rst   - synchronous active-high reset
//            meas_clk  - clock under test, sampled as data
//            start     - one-cycle request to begin a measurement
//            cont      - continuous mode, sampled in REPORT
//            freq_cnt  - edges counted in the last completed window
//            cnt_valid - one-cycle pulse when freq_cnt updates
//            busy      - high while measuring or reporting
//            in_range  - last result within tolerance and not saturated
//            overflow  - last window's edge count saturated
// Revision : 1.0 - initial release
// ============================================================================
module clk_freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int EXP_CNT     = 250,
    parameter int TOL         = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             meas_clk,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             cnt_valid,
    output logic             busy,
    output logic             in_range,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GATE   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    // Tolerance bounds are compared one bit wider than the counter so that
    // EXP_CNT+TOL may exceed the counter's range; the lower bound clamps at 0.
    localparam int             c_lo_int    = (EXP_CNT > TOL) ? (EXP_CNT - TOL) : 0;
    localparam int             c_hi_int    = EXP_CNT + TOL;
    localparam logic [CNT_W:0] c_lo        = c_lo_int[CNT_W:0];
    localparam logic [CNT_W:0] c_hi        = c_hi_int[CNT_W:0];
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [15:0]    c_gate_last = 16'(GATE_CYCLES - 1);

    state_t           state_q,    state_d;
    logic             sync1_q,    sync2_q,   prev_q;
    logic [15:0]      gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             ovf_acc_q,  ovf_acc_d;
    logic [CNT_W-1:0] freq_cnt_q, freq_cnt_d;
    logic             overflow_q, overflow_d;
    logic             in_range_q, in_range_d;

    logic             w_edge_pulse;
    logic             w_at_max;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_ovf_next;
    logic [CNT_W:0]   w_cnt_ext;

    // Rising edge of the synchronised clock under test.
    assign w_edge_pulse = sync2_q & ~prev_q;

    // Saturating increment; an edge arriving at saturation marks the window.
    assign w_at_max   = (edge_cnt_q == c_cnt_max);
    assign w_cnt_next = (w_edge_pulse && !w_at_max) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    assign w_ovf_next = ovf_acc_q | (w_edge_pulse & w_at_max);
    assign w_cnt_ext  = {1'b0, w_cnt_next};

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_acc_d  = ovf_acc_q;
        freq_cnt_d = freq_cnt_q;
        overflow_d = overflow_q;
        in_range_d = in_range_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_GATE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    ovf_acc_d  = 1'b0;
                end
            end
            S_GATE: begin
                edge_cnt_d = w_cnt_next;
                ovf_acc_d  = w_ovf_next;
                gate_cnt_d = gate_cnt_q + 16'd1;
                // The last gate cycle's pulse is folded straight into the result.
                if (gate_cnt_q == c_gate_last) begin
                    state_d    = S_REPORT;
                    freq_cnt_d = w_cnt_next;
                    overflow_d = w_ovf_next;
                    in_range_d = !w_ovf_next && (w_cnt_ext >= c_lo) && (w_cnt_ext <= c_hi);
                end
            end
            S_REPORT: begin
                if (cont) begin
                    state_d    = S_GATE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    ovf_acc_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_acc_q  <= 1'b0;
            freq_cnt_q <= '0;
            overflow_q <= 1'b0;
            in_range_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= meas_clk;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_acc_q  <= ovf_acc_d;
            freq_cnt_q <= freq_cnt_d;
            overflow_q <= overflow_d;
            in_range_q <= in_range_d;
        end
    end

    assign freq_cnt  = freq_cnt_q;
    assign overflow  = overflow_q;
    assign in_range  = in_range_q;
    assign cnt_valid = (state_q == S_REPORT);
    assign busy      = (state_q == S_GATE) || (state_q == S_REPORT);

endmodule
`default_nettype wire

// File: tb/tb_clk_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_freq_meter
// Purpose  : Self-checking bench for clk_freq_meter; expected reports are
//            queued when a measurement is launched and checked on cnt_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_freq_meter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        meas_clk = 1'b0;
    logic        start = 1'b0;
    logic        start8 = 1'b0;
    logic        cont = 1'b0;
    logic [15:0] freq_cnt;
    logic        cnt_valid, busy, in_range, overflow;
    logic [7:0]  freq_cnt8;
    logic        cnt_valid8, busy8, in_range8, overflow8;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int per     = 0;
    int ph      = 0;

    typedef struct {
        int cnt;
        int ovf;
        int inr;
        int due;
    } exp_t;
    exp_t sb[$];

    clk_freq_meter dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .meas_clk (meas_clk),
        .start    (start),
        .cont     (cont),
        .freq_cnt (freq_cnt),
        .cnt_valid(cnt_valid),
        .busy     (busy),
        .in_range (in_range),
        .overflow (overflow)
    );

    clk_freq_meter #(.GATE_CYCLES(1000), .CNT_W(8), .EXP_CNT(250), .TOL(2)) dut8 (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .meas_clk (meas_clk),
        .start    (start8),
        .cont     (1'b0),
        .freq_cnt (freq_cnt8),
        .cnt_valid(cnt_valid8),
        .busy     (busy8),
        .in_range (in_range8),
        .overflow (overflow8)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Clock under test: period 'per' sys_clk cycles, high for per/2; 0 = held low.
    always @(negedge sys_clk) begin
        if (per == 0) begin
            ph       = 0;
            meas_clk = 1'b0;
        end else begin
            ph       = (ph + 1 >= per) ? 0 : ph + 1;
            meas_clk = (ph < per / 2);
        end
    end

    task automatic check(input string tag, input int obs, input int expv);
        n_total++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer: every cnt_valid must match the oldest queued report.
    always @(negedge sys_clk) begin
        if (cnt_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("valid_cycle", cyc, e.due);
                check("freq_cnt", int'(freq_cnt), e.cnt);
                check("overflow", int'(overflow), e.ovf);
                check("in_range", int'(in_range), e.inr);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Pulses start for one cycle; returns the cycle count at the drive point.
    task automatic pulse_start(output int s);
        @(negedge sys_clk);
        start = 1'b1;
        s     = cyc;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic push(input int cnt, input int ovf, input int inr, input int due);
        exp_t e;
        e.cnt = cnt; e.ovf = ovf; e.inr = inr; e.due = due;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic set_period(input int p);
        @(negedge sys_clk);
        per = p;
        tick(10);
    endtask

    initial begin
        int s;
        int k;

        // Reset with start held high: start must be ignored.
        sys_rst = 1'b1;
        start   = 1'b1;
        tick(3);
        sys_rst = 1'b0;
        start   = 1'b0;
        check("rst_freq_cnt", int'(freq_cnt), 0);
        check("rst_cnt_valid", int'(cnt_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_range", int'(in_range), 0);
        check("rst_overflow", int'(overflow), 0);
        tick(1);
        check("rst_start_ignored", int'(busy), 0);

        // Nominal period-4 measurement.
        set_period(4);
        pulse_start(s);
        push(250, 0, 1, s + 1001);
        check("busy_in_gate", int'(busy), 1);
        drain(1200);
        tick(1);
        check("idle_after_report", int'(busy), 0);

        // Clock held low.
        set_period(0);
        pulse_start(s);
        push(0, 0, 0, s + 1001);
        drain(1200);

        // Period 5 is out of tolerance.
        set_period(5);
        pulse_start(s);
        push(200, 0, 0, s + 1001);
        drain(1200);

        // Re-pulsing start during GATE must not restart the window.
        set_period(4);
        pulse_start(s);
        push(250, 0, 1, s + 1001);
        tick(300);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        drain(1200);
        tick(5);
        check("no_restart_busy", int'(busy), 0);

        // Reset mid-GATE aborts silently and clears outputs.
        pulse_start(s);
        while (cyc < s + 500) @(negedge sys_clk);
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        check("abort_freq_cnt", int'(freq_cnt), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_range", int'(in_range), 0);
        check("abort_cnt_valid", int'(cnt_valid), 0);
        tick(1100);
        pulse_start(s);
        push(250, 0, 1, s + 1001);
        drain(1200);

        // Continuous mode, dropped partway through the third window.
        @(negedge sys_clk);
        cont = 1'b1;
        pulse_start(s);
        push(250, 0, 1, s + 1001);
        push(250, 0, 1, s + 2002);
        push(250, 0, 1, s + 3003);
        while (cyc < s + 2502) @(negedge sys_clk);
        cont = 1'b0;
        drain(1200);
        tick(1);
        check("cont_stop_busy", int'(busy), 0);

        // Saturation on the narrow-counter instance.
        set_period(2);
        @(negedge sys_clk);
        start8 = 1'b1;
        s      = cyc;
        @(negedge sys_clk);
        start8 = 1'b0;
        k = 0;
        while (cnt_valid8 !== 1'b1 && k < 1200) begin
            @(negedge sys_clk);
            k++;
        end
        check("sat_valid_cycle", cyc, s + 1001);
        check("sat_freq_cnt", int'(freq_cnt8), 255);
        check("sat_overflow", int'(overflow8), 1);
        check("sat_in_range", int'(in_range8), 0);

        tick(5);
        check("queue_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
